vpl_mul_sched: RTL and testbench

//  Two-requester scheduler for one shared shift-add multiplier (PH/MPL register pair, carry DFF, adder).

---
 rtl/vpl_mul_pkg.sv | 23 ++
 rtl/vpl_rr_arb2.sv | 20 ++
 rtl/vpl_mul_sched.sv | 138 +++++++++++++
 tb/tb_vpl_mul_sched.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vpl_mul_pkg.sv
// Shared widths and state encoding for the vpl_mul_sched shift-add multiplier scheduler.
// Optional build macro used by the top: VPL_MUL_EARLY_TERM_EN.
package vpl_mul_pkg;

  localparam int DEF_MCAND_W = 8;
  localparam int DEF_MPLR_W  = 4;
  localparam int DEF_PROD_W  = DEF_MCAND_W + DEF_MPLR_W;
  localparam int DEF_CNT_W   = $clog2(DEF_MPLR_W + 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADD   = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Flat constants for code that keeps the state in a plain logic vector.
  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ADD   = ST_ADD;
  localparam logic [1:0] S_SHIFT = ST_SHIFT;
  localparam logic [1:0] S_DONE  = ST_DONE;

endpackage

// File: rtl/vpl_rr_arb2.sv
// Two-way round-robin grant: a lone request wins, a tie goes to the requester that was not last owner.
module vpl_rr_arb2 (
  input  logic req0,
  input  logic req1,
  input  logic owner,
  output logic grant,
  output logic any
);

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~owner;
    end else if (req1) begin
      grant = 1'b1;
    end
    any = req0 | req1;
  end

endmodule

// File: rtl/vpl_mul_sched.sv
// Round-robin scheduler around one shared shift-add multiplier (PH/MPL pair, carry, adder).
// Build macro VPL_MUL_EARLY_TERM_EN: finish as soon as the remaining multiplier bits are zero.
import vpl_mul_pkg::*;

module vpl_mul_sched #(
  parameter int MCAND_W = DEF_MCAND_W,
  parameter int MPLR_W  = DEF_MPLR_W
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      req0,
  input  logic [MCAND_W-1:0]        a0,
  input  logic [MPLR_W-1:0]         b0,
  input  logic                      req1,
  input  logic [MCAND_W-1:0]        a1,
  input  logic [MPLR_W-1:0]         b1,
  output logic                      ack0,
  output logic                      ack1,
  output logic [MCAND_W+MPLR_W-1:0] prod,
  output logic                      busy,
  output logic                      owner,
  output logic [1:0]                state_dbg
);

  // Handshake: reqN is a level held by the client; it is sampled only in IDLE,
  // operands are captured on the grant edge, and ackN is a single-cycle pulse
  // during which prod is valid. A req still high after its ack is a new request.

  localparam int PROD_W = MCAND_W + MPLR_W;
  localparam int CNT_W  = $clog2(MPLR_W + 1);

  logic [1:0]         state;
  logic [MCAND_W-1:0] mcand;
  logic [MCAND_W-1:0] ph;
  logic [MPLR_W-1:0]  mpl;
  logic               carry;
  logic [CNT_W-1:0]   count;
  logic               owner_q;
  logic [PROD_W-1:0]  prod_q;

  logic               grant;
  logic               req_any;
  logic [MCAND_W:0]   sum;
  logic [PROD_W-1:0]  shifted;
  logic [PROD_W-1:0]  shift_next;
  logic [CNT_W-1:0]   count_dec;
  logic               shift_last;

  vpl_rr_arb2 u_arb (
    .req0  (req0),
    .req1  (req1),
    .owner (owner_q),
    .grant (grant),
    .any   (req_any)
  );

  assign sum       = {1'b0, ph} + {1'b0, mcand};
  assign shifted   = {carry, ph, mpl[MPLR_W-1:1]};
  assign count_dec = count - 1'b1;

`ifdef VPL_MUL_EARLY_TERM_EN
  // The low count_dec bits of the shifted MPL are the multiplier bits not yet consumed.
  logic [MPLR_W-1:0] one_w;
  logic [MPLR_W-1:0] rem_mask;
  logic              rem_zero;

  always_comb begin
    one_w      = {{(MPLR_W-1){1'b0}}, 1'b1};
    rem_mask   = (one_w << count_dec) - one_w;
    rem_zero   = ((shifted[MPLR_W-1:0] & rem_mask) == '0);
    shift_next = rem_zero ? (shifted >> count_dec) : shifted;
    shift_last = rem_zero;
  end
`else
  always_comb begin
    shift_next = shifted;
    shift_last = (count_dec == '0);
  end
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      mcand   <= '0;
      ph      <= '0;
      mpl     <= '0;
      carry   <= 1'b0;
      count   <= '0;
      owner_q <= 1'b1;
      prod_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_any) begin
            owner_q <= grant;
            mcand   <= grant ? a1 : a0;
            mpl     <= grant ? b1 : b0;
            ph      <= '0;
            carry   <= 1'b0;
            count   <= CNT_W'(MPLR_W);
            state   <= S_ADD;
          end
        end
        S_ADD: begin
          if (mpl[0]) begin
            {carry, ph} <= sum;
          end
          state <= S_SHIFT;
        end
        S_SHIFT: begin
          {ph, mpl} <= shift_next;
          carry     <= 1'b0;
          count     <= count_dec;
          if (shift_last) begin
            prod_q <= shift_next;
            state  <= S_DONE;
          end else begin
            state  <= S_ADD;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign ack0      = (state == S_DONE) && !owner_q;
  assign ack1      = (state == S_DONE) && owner_q;
  assign busy      = (state != S_IDLE);
  assign owner     = owner_q;
  assign prod      = prod_q;
  assign state_dbg = state;

endmodule

// File: tb/tb_vpl_mul_sched.sv
// Self-checking bench for vpl_mul_sched: directed vectors plus randomized jobs against a reference model.
module tb_vpl_mul_sched;
  import vpl_mul_pkg::*;

  localparam int MW = 8;
  localparam int PW = 4;
  localparam int RW = MW + PW;

  logic          clock;
  logic          reset;
  logic          req0;
  logic [MW-1:0] a0;
  logic [PW-1:0] b0;
  logic          req1;
  logic [MW-1:0] a1;
  logic [PW-1:0] b1;
  logic          ack0;
  logic          ack1;
  logic [RW-1:0] prod;
  logic          busy;
  logic          owner;
  logic [1:0]    state_dbg;

  int checks = 0;
  int fails  = 0;
  bit model_owner;
  logic [RW:0] exp_q[$];
  logic [MW-1:0] ops_a[2][4];
  logic [PW-1:0] ops_b[2][4];

  vpl_mul_sched dut (
    .clock     (clock),
    .reset     (reset),
    .req0      (req0),
    .a0        (a0),
    .b0        (b0),
    .req1      (req1),
    .a1        (a1),
    .b1        (b1),
    .ack0      (ack0),
    .ack1      (ack1),
    .prod      (prod),
    .busy      (busy),
    .owner     (owner),
    .state_dbg (state_dbg)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference latency: a full pass is two edges per multiplier bit; early exit stops after the top set bit.
  function automatic int exp_lat(input logic [PW-1:0] b);
    int k;
    k = PW;
`ifdef VPL_MUL_EARLY_TERM_EN
    k = 1;
    for (int i = 0; i < PW; i++) if (b[i]) k = i + 1;
`endif
    return 2 * k;
  endfunction

  task automatic reset_dut();
    reset = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    a0 = '0; b0 = '0; a1 = '0; b1 = '0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    model_owner = 1'b1;
  endtask

  // One job from a single requester on an idle DUT; checks grant, latency, product and the idle return.
  task automatic do_job(input bit id, input logic [MW-1:0] a, input logic [PW-1:0] b,
                        input bit drop_early, input string name);
    int lat;
    int p;
    int el;
    bit got;
    bit wrong;
    logic [RW-1:0] pexp;
    p = int'(a) * int'(b);
    pexp = p[RW-1:0];
    el = exp_lat(b);
    if (id) begin req1 = 1'b1; a1 = a; b1 = b; end
    else    begin req0 = 1'b1; a0 = a; b0 = b; end
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b1 || owner !== id) begin
      fails++;
      $display("FAIL %s capture: busy=%b owner=%b, need busy=1 owner=%0d", name, busy, owner, id);
    end
    model_owner = id;
    got = 1'b0; wrong = 1'b0; lat = 0;
    while (!got && lat < 40) begin
      @(posedge clock); #1;
      lat++;
      if (drop_early && lat == 1) begin
        if (id) req1 = 1'b0; else req0 = 1'b0;
      end
      if ((id ? ack0 : ack1) === 1'b1) wrong = 1'b1;
      if ((id ? ack1 : ack0) === 1'b1) got = 1'b1;
    end
    checks++;
    if (!got || lat != el) begin
      fails++;
      $display("FAIL %s latency: got ack=%b after %0d edges, need ack after %0d", name, got, lat, el);
    end
    checks++;
    if (prod !== pexp) begin
      fails++;
      $display("FAIL %s prod: got %h, need %h", name, prod, pexp);
    end
    checks++;
    if (wrong) begin
      fails++;
      $display("FAIL %s other_ack: other requester acked, need never", name);
    end
    req0 = 1'b0; req1 = 1'b0;
    @(posedge clock); #1;
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      fails++;
      $display("FAIL %s idle: busy=%b ack0=%b ack1=%b, need all 0", name, busy, ack0, ack1);
    end
  endtask

  // Both requesters hold req for n jobs each; grants must alternate starting from the non-owner.
  task automatic run_pair(input int n, input string name);
    int idx[2];
    int cyc;
    int p;
    bit start;
    bit r;
    logic [RW:0] e;
    logic [RW-1:0] pv;
    exp_q.delete();
    start = ~model_owner;
    for (int j = 0; j < 2 * n; j++) begin
      r = start ^ j[0];
      p = int'(ops_a[r][j/2]) * int'(ops_b[r][j/2]);
      pv = p[RW-1:0];
      exp_q.push_back({r, pv});
    end
    idx[0] = 0; idx[1] = 0;
    req0 = 1'b1; a0 = ops_a[0][0]; b0 = ops_b[0][0];
    req1 = 1'b1; a1 = ops_a[1][0]; b1 = ops_b[1][0];
    cyc = 0;
    while (exp_q.size() > 0 && cyc < 400) begin
      @(posedge clock); #1;
      cyc++;
      if (ack0 === 1'b1 && ack1 === 1'b1) begin
        checks++;
        fails++;
        $display("FAIL %s dual_ack: ack0=1 ack1=1, need at most one", name);
      end else if (ack0 === 1'b1 || ack1 === 1'b1) begin
        r = ack1;
        e = exp_q.pop_front();
        checks++;
        if ({r, prod} !== e) begin
          fails++;
          $display("FAIL %s ack_order: got id=%0d prod=%h, need id=%0d prod=%h",
                   name, r, prod, e[RW], e[RW-1:0]);
        end
        model_owner = r;
        idx[r]++;
        if (idx[r] < n) begin
          if (r) begin a1 = ops_a[1][idx[1]]; b1 = ops_b[1][idx[1]]; end
          else   begin a0 = ops_a[0][idx[0]]; b0 = ops_b[0][idx[0]]; end
        end else begin
          if (r) req1 = 1'b0; else req0 = 1'b0;
        end
        if (exp_q.size() > 0) begin
          @(posedge clock); #1;
          checks++;
          if (busy !== 1'b0) begin
            fails++;
            $display("FAIL %s gap_idle: busy=%b, need 0", name, busy);
          end
          @(posedge clock); #1;
          checks++;
          if (busy !== 1'b1) begin
            fails++;
            $display("FAIL %s gap_regrant: busy=%b, need 1", name, busy);
          end
          cyc += 2;
        end
      end
    end
    checks++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL %s timeout: %0d acks outstanding, need 0", name, exp_q.size());
    end
    req0 = 1'b0; req1 = 1'b0;
    repeat (2) @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset_dut();
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || ack1 !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs: busy=%b ack0=%b ack1=%b, need 0 0 0", busy, ack0, ack1);
    end
    checks++;
    if (owner !== 1'b1) begin
      fails++;
      $display("FAIL reset_owner: got %b, need 1", owner);
    end
    checks++;
    if (state_dbg !== S_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d, need %0d", state_dbg, S_IDLE);
    end
  endtask

  task automatic test_contention();
    reset_dut();
    ops_a[0][0] = 8'hFF; ops_b[0][0] = 4'hF;
    ops_a[1][0] = 8'h03; ops_b[1][0] = 4'h2;
    run_pair(1, "contention");
  endtask

  task automatic test_vectors();
    do_job(1'b0, 8'hC8, 4'hD, 1'b0, "vec_c8xd");
    do_job(1'b0, 8'h00, 4'hF, 1'b0, "vec_zero");
    do_job(1'b1, 8'h7F, 4'h1, 1'b0, "vec_ident");
    do_job(1'b0, 8'h10, 4'h8, 1'b1, "vec_drop");
  endtask

  task automatic test_reset_mid();
    logic [MW-1:0] a;
    logic [PW-1:0] b;
    bit saw_ack;
    a = MW'($urandom_range(1, 255));
    b = PW'($urandom_range(8, 15));
    req0 = 1'b1; a0 = a; b0 = b;
    repeat (3) @(posedge clock);
    #1 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || ack0 !== 1'b0 || owner !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_abort: busy=%b ack0=%b owner=%b, need 0 0 1", busy, ack0, owner);
    end
    saw_ack = 1'b0;
    repeat (2) begin
      @(posedge clock); #1;
      if (ack0 === 1'b1 || ack1 === 1'b1) saw_ack = 1'b1;
    end
    checks++;
    if (saw_ack) begin
      fails++;
      $display("FAIL reset_mid_noack: ack seen during reset, need none");
    end
    reset = 1'b0;
    model_owner = 1'b1;
    do_job(1'b0, a, b, 1'b0, "reset_mid_retry");
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        ops_a[r][k] = MW'($urandom_range(0, 255));
        ops_b[r][k] = PW'($urandom_range(0, 15));
      end
    run_pair(2, "b2b_from_reset");
    for (int r = 0; r < 2; r++)
      for (int k = 0; k < 4; k++) begin
        ops_a[r][k] = MW'($urandom_range(0, 255));
        ops_b[r][k] = PW'($urandom_range(0, 15));
      end
    run_pair(3, "b2b_random");
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++) begin
      do_job(1'($urandom_range(0, 1)), MW'($urandom_range(0, 255)),
             PW'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), "random_job");
    end
  endtask

  initial begin
    test_reset();
    test_contention();
    test_vectors();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
